// File: rtl/tdp_ram_pkg.sv
// Shared constants and the byte-merge helper for the parametrised true dual-port RAM.
package tdp_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W  = 1024;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] be_merge(
    input logic [MERGE_W-1:0]  old,
    input logic [MERGE_W-1:0]  din,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old;
    for (int i = 0; i < MERGE_BE; i++) begin
      res[i*8 +: 8] = be[i] ? din[i*8 +: 8] : old[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tdp_ram_port_pipe.sv
// Per-port result select, optional output register and flag alignment so that
// dout/vld and the pulse flags always leave the RAM on the same cycle.
module tdp_ram_port_pipe
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic              oor,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_word,
  input  logic [2:0]        flags_in,
  output logic [DATA_W-1:0] dout,
  output logic              vld,
  output logic [2:0]        flags
);

  logic              emit_s;
  logic [DATA_W-1:0] data_s;
  logic              s1_vld_r;
  logic [DATA_W-1:0] s1_dout_r;
  logic [2:0]        s1_flags_r;

  // Pick the word this access returns; no-change writes emit nothing.
  always_comb begin
    emit_s = en & (~we | (RDW_MODE != RDW_NO_CHANGE));
    if (oor) begin
      data_s = '0;
    end else if (we && (RDW_MODE == RDW_WRITE_FIRST)) begin
      data_s = new_word;
    end else begin
      data_s = old_word;
    end
  end

  // First result stage; dout only moves when a new result is due.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r   <= 1'b0;
      s1_dout_r  <= '0;
      s1_flags_r <= 3'b000;
    end else begin
      s1_vld_r   <= emit_s;
      s1_flags_r <= flags_in;
      if (emit_s) begin
        s1_dout_r <= data_s;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s2_vld_r;
      logic [DATA_W-1:0] s2_dout_r;
      logic [2:0]        s2_flags_r;

      // Extra output stage; flags ride along to stay aligned with vld.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld_r   <= 1'b0;
          s2_dout_r  <= '0;
          s2_flags_r <= 3'b000;
        end else begin
          s2_vld_r   <= s1_vld_r;
          s2_flags_r <= s1_flags_r;
          if (s1_vld_r) begin
            s2_dout_r <= s1_dout_r;
          end
        end
      end

      assign dout  = s2_dout_r;
      assign vld   = s2_vld_r;
      assign flags = s2_flags_r;
    end else begin : g_noreg
      assign dout  = s1_dout_r;
      assign vld   = s1_vld_r;
      assign flags = s1_flags_r;
    end
  endgenerate

endmodule

// File: rtl/tdp_ram_param.sv
// Parametrised single-clock true dual-port RAM with byte enables, selectable
// read-during-write behaviour, collision flags and an out-of-range guard.
module tdp_ram_param
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0,
  parameter int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [BE_W-1:0]   a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_vld,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [BE_W-1:0]   b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_vld,
  output logic              coll_ww,
  output logic              coll_rw,
  output logic              oor_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              a_inr_s, b_inr_s, a_wr_s, b_wr_s, a_rd_s, b_rd_s, same_s;
  logic              a_oor_s, b_oor_s, a_wr_g_s, b_wr_g_s, coll_ww_s, coll_rw_s;
  logic [DATA_W-1:0] a_old_s, b_old_s, a_base_s, a_new_s, b_new_s, b_post_s;
  logic [2:0]        a_flags_s, b_flags_s;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old,
    input logic [DATA_W-1:0] din,
    input logic [BE_W-1:0]   be
  );
    return DATA_W'(be_merge(MERGE_W'(old), MERGE_W'(din), MERGE_BE'(be)));
  endfunction

  // Access decode, collision compare and the merged words written this cycle.
  always_comb begin
    a_inr_s   = {1'b0, a_addr} < DEPTH_C;
    b_inr_s   = {1'b0, b_addr} < DEPTH_C;
    a_wr_s    = a_en & a_we & a_inr_s;
    b_wr_s    = b_en & b_we & b_inr_s;
    a_rd_s    = a_en & ~a_we & a_inr_s;
    b_rd_s    = b_en & ~b_we & b_inr_s;
    a_oor_s   = a_en & ~a_inr_s;
    b_oor_s   = b_en & ~b_inr_s;
    same_s    = (a_addr == b_addr);
    coll_ww_s = a_wr_s & b_wr_s & same_s;
    coll_rw_s = same_s & ((a_rd_s & b_wr_s) | (b_rd_s & a_wr_s));
    a_wr_g_s  = a_wr_s & rst_n;
    b_wr_g_s  = b_wr_s & rst_n;
    a_old_s   = a_inr_s ? mem[a_addr] : '0;
    b_old_s   = b_inr_s ? mem[b_addr] : '0;
    b_new_s   = merge(b_old_s, b_din, b_be);
    // Port A is merged on top of port B so bytes both enable end up with A data.
    a_base_s  = coll_ww_s ? b_new_s : a_old_s;
    a_new_s   = merge(a_base_s, a_din, a_be);
    b_post_s  = coll_ww_s ? a_new_s : b_new_s;
    a_flags_s = {coll_ww_s, coll_rw_s, a_oor_s};
    b_flags_s = {2'b00, b_oor_s};
  end

  // Storage array; A is written last so its merged word wins on a shared address.
  always_ff @(posedge clk) begin
    if (b_wr_g_s) begin
      mem[b_addr] <= b_new_s;
    end
    if (a_wr_g_s) begin
      mem[a_addr] <= a_new_s;
    end
  end

  logic [2:0] a_fl_out_s, b_fl_out_s;

  tdp_ram_port_pipe #(
    .DATA_W(DATA_W), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
  ) u_pipe_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .we(a_we), .oor(a_oor_s),
    .old_word(a_old_s), .new_word(a_new_s), .flags_in(a_flags_s),
    .dout(a_dout), .vld(a_vld), .flags(a_fl_out_s)
  );

  tdp_ram_port_pipe #(
    .DATA_W(DATA_W), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
  ) u_pipe_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .we(b_we), .oor(b_oor_s),
    .old_word(b_old_s), .new_word(b_post_s), .flags_in(b_flags_s),
    .dout(b_dout), .vld(b_vld), .flags(b_fl_out_s)
  );

  assign coll_ww = a_fl_out_s[2] | b_fl_out_s[2];
  assign coll_rw = a_fl_out_s[1] | b_fl_out_s[1];
  assign oor_err = a_fl_out_s[0] | b_fl_out_s[0];

endmodule

// File: tb/tb_tdp_ram_param.sv
// Scoreboard bench: three RAM instances (read-first, write-first + output register,
// no-change) driven by the same directed vectors; a negedge monitor checks results.
module tb_tdp_ram_param;

  localparam int N = 3;
  localparam int OREG [N] = '{0, 1, 0};
  localparam int RDW  [N] = '{0, 1, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_en [N], a_we [N], b_en [N], b_we [N];
  logic [3:0]  a_be [N], b_be [N];
  logic [7:0]  a_addr [N], b_addr [N];
  logic [31:0] a_din [N], b_din [N], a_dout [N], b_dout [N];
  logic        a_vld [N], b_vld [N], coll_ww [N], coll_rw [N], oor_err [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    tdp_ram_param #(
      .DATA_W(32), .ADDR_W(8), .DEPTH(200), .RDW_MODE(RDW[g]), .OUT_REG(OREG[g])
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .a_en(a_en[g]), .a_we(a_we[g]), .a_be(a_be[g]), .a_addr(a_addr[g]),
      .a_din(a_din[g]), .a_dout(a_dout[g]), .a_vld(a_vld[g]),
      .b_en(b_en[g]), .b_we(b_we[g]), .b_be(b_be[g]), .b_addr(b_addr[g]),
      .b_din(b_din[g]), .b_dout(b_dout[g]), .b_vld(b_vld[g]),
      .coll_ww(coll_ww[g]), .coll_rw(coll_rw[g]), .oor_err(oor_err[g])
    );
  end

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          care;
  } exp_t;

  exp_t       q [2*N][$];
  logic [2:0] exp_fl [N][512];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_port(input int idx, input logic v, input logic [31:0] d);
    exp_t e;
    if (v) begin
      n_cmp++;
      if (q[idx].size() == 0) begin
        n_bad++;
        $display("FAIL spurious_vld port%0d: got vld=1 want no result (cycle %0d)", idx, cyc);
      end else begin
        e = q[idx].pop_front();
        if (e.due != cyc || (e.care && d !== e.data)) begin
          n_bad++;
          $display("FAIL port_data port%0d: got %h at cycle %0d want %h at cycle %0d",
                   idx, d, cyc, e.data, e.due);
        end
      end
    end else if (q[idx].size() > 0 && q[idx][0].due < cyc) begin
      e = q[idx].pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed_vld port%0d: got no vld want %h at cycle %0d", idx, e.data, e.due);
    end
  endtask

  // Monitor: flag pulses every cycle, read results whenever vld is presented.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk($sformatf("flags dut%0d", k), {29'd0, coll_ww[k], coll_rw[k], oor_err[k]},
          {29'd0, exp_fl[k][cyc % 512]});
      check_port(2*k, a_vld[k], a_dout[k]);
      check_port(2*k + 1, b_vld[k], b_dout[k]);
    end
  end

  // One access on every instance; the expected result depends on its RDW mode.
  task automatic acc(input bit pb, input bit we, input logic [3:0] be, input logic [7:0] addr,
                     input logic [31:0] din, input logic [31:0] old_w, input bit care_old,
                     input logic [31:0] new_w, input bit care_new);
    for (int k = 0; k < N; k++) begin
      if (!pb) begin
        a_en[k] = 1'b1; a_we[k] = we; a_be[k] = be; a_addr[k] = addr; a_din[k] = din;
      end else begin
        b_en[k] = 1'b1; b_we[k] = we; b_be[k] = be; b_addr[k] = addr; b_din[k] = din;
      end
      if (!we || RDW[k] == 0) push(2*k + int'(pb), cyc + 1 + OREG[k], old_w, care_old);
      else if (RDW[k] == 1) push(2*k + int'(pb), cyc + 1 + OREG[k], new_w, care_new);
    end
  endtask

  task automatic push(input int idx, input int due, input logic [31:0] d, input bit care);
    exp_t e;
    e.due = due; e.data = d; e.care = care;
    q[idx].push_back(e);
  endtask

  task automatic rd(input bit pb, input logic [7:0] addr, input logic [31:0] exp);
    acc(pb, 1'b0, 4'h0, addr, 32'h0, exp, 1'b1, exp, 1'b1);
  endtask

  task automatic expect_fl(input logic [2:0] f);
    for (int k = 0; k < N; k++) exp_fl[k][(cyc + 1 + OREG[k]) % 512] |= f;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      a_en[k] = 1'b0; b_en[k] = 1'b0;
    end
  endtask

  logic [7:0]  w_addr [5] = '{8'd3, 8'd5, 8'd7, 8'h10, 8'd199};
  logic [31:0] w_data [5] = '{32'hAA, 32'h3C, 32'h99, 32'hFFFF_FFFF, 32'hC7};
  logic [31:0] w_old  [5] = '{32'd3, 32'd5, 32'd7, 32'h0, 32'h0};
  bit          w_care [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    for (int k = 0; k < N; k++) begin
      a_en[k] = 1'b0; a_we[k] = 1'b0; a_be[k] = 4'h0; a_addr[k] = 8'h0; a_din[k] = 32'h0;
      b_en[k] = 1'b0; b_we[k] = 1'b0; b_be[k] = 4'h0; b_addr[k] = 8'h0; b_din[k] = 32'h0;
      for (int c = 0; c < 512; c++) exp_fl[k][c] = 3'b000;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("reset a_dout", a_dout[k], 32'h0);
      chk("reset b_dout", b_dout[k], 32'h0);
      chk("reset vld", {30'd0, a_vld[k], b_vld[k]}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Preload addr 0..9 with value = addr through port B, then stream them back.
    for (int i = 0; i < 10; i++) begin
      acc(1'b1, 1'b1, 4'hF, 8'(i), 32'(i), 32'h0, 1'b0, 32'(i), 1'b1);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      rd(1'b1, 8'(i), 32'(i));
      step();
    end

    for (int i = 0; i < 5; i++) begin
      acc(1'b0, 1'b1, 4'hF, w_addr[i], w_data[i], w_old[i], w_care[i], w_data[i], 1'b1);
      step();
    end

    // Byte-enable merge.
    acc(1'b0, 1'b1, 4'b0101, 8'h10, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 32'hFF34_FF78, 1'b1);
    step();
    rd(1'b0, 8'h10, 32'hFF34_FF78);
    step();

    // Same-port read-during-write; the no-change instance must hold its last result.
    acc(1'b0, 1'b1, 4'hF, 8'd3, 32'h55, 32'hAA, 1'b1, 32'h55, 1'b1);
    step();
    chk("rdw2 hold dout", a_dout[2], 32'hFF34_FF78);
    chk("rdw2 hold vld", {31'd0, a_vld[2]}, 32'h0);
    rd(1'b0, 8'd3, 32'h55);
    step();

    // Cross-port read vs write: reader sees the old word.
    acc(1'b0, 1'b1, 4'hF, 8'd7, 32'h11, 32'h99, 1'b1, 32'h11, 1'b1);
    rd(1'b1, 8'd7, 32'h99);
    expect_fl(3'b010);
    step();

    // Write/write on the same address: port A wins.
    acc(1'b0, 1'b1, 4'hF, 8'd7, 32'h22, 32'h11, 1'b1, 32'h22, 1'b1);
    acc(1'b1, 1'b1, 4'hF, 8'd7, 32'h33, 32'h11, 1'b1, 32'h0, 1'b0);
    expect_fl(3'b100);
    step();
    rd(1'b0, 8'd7, 32'h22);
    step();

    // Out of range: suppressed write, zero read, no collision flags.
    acc(1'b0, 1'b1, 4'hF, 8'd200, 32'h77, 32'h0, 1'b0, 32'h0, 1'b0);
    rd(1'b1, 8'd200, 32'h0);
    expect_fl(3'b001);
    step();
    rd(1'b0, 8'd200, 32'h0);
    expect_fl(3'b001);
    step();
    rd(1'b0, 8'd199, 32'hC7);
    step();
    rd(1'b0, 8'd0, 32'h0);
    step();
    repeat (3) step();

    // Reset while a registered read is in flight on the OUT_REG instance.
    a_en[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 8'd5;
    step();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) chk("midreset a_dout", a_dout[k], 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset a_vld", {31'd0, a_vld[1]}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    rd(1'b0, 8'd5, 32'h3C);
    step();
    repeat (4) step();

    for (int i = 0; i < 2*N; i++) chk($sformatf("leftover port%0d", i), 32'(q[i].size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
